audio_dac: RTL and testbench
============================

// Module: audio_dac
// PURPOSE
//   Multi-channel 1-bit audio DAC. Accepts signed PCM frames from the GB APU
//   (left/right mixer outputs) and drives one digital pin per channel.
//   Each pin is either PWM or first-order sigma-delta, selectable at run time.
//   Double-buffered sample intake with valid/ready handshake and underrun flag.
//   Supersedes the fixed 9-bit per-pin PWM instances.
// PARAMETERS
//   CHANNELS  2   number of audio channels / output pins
//   IN_WIDTH  16  signed input sample width per channel
//   WIDTH     9   DAC resolution in bits; frame period = 2**WIDTH clk cycles
// PORTS
//   clk           in   1                   DAC clock (sample rate = clk / 2**WIDTH)
//   rst           in   1                   synchronous reset, active high
//   sample        in   CHANNELS*IN_WIDTH   packed signed samples, ch0 in [IN_WIDTH-1:0]
//   sample_valid  in   1                   sample is presented
//   sample_ready  out  1                   pending buffer empty; sample is taken on valid&&ready
//   mode          in   1                   0 = PWM, 1 = sigma-delta
//   mute          in   1                   force all outputs low
//   frame_start   out  1                   one-cycle pulse, counter == 0
//   underrun      out  1                   one-cycle pulse: frame boundary with pending empty
//   dac_out       out  CHANNELS            1-bit audio outputs, registered
// BEHAVIOUR
// - Conversion, per channel: duty = {~s[IN_WIDTH-1], s[IN_WIDTH-2 -: WIDTH-1]}.
//   Signed to offset binary, top WIDTH bits, no rounding. 0x0000 maps to 2**(WIDTH-1).
// - Counter cnt (WIDTH bits) increments every clk and wraps 2**WIDTH-1 -> 0.
//   frame_start = (cnt == 0), combinational from the register.
// - Buffers: a pending register (duty[CHANNELS], flag pend_full) and an active register.
//   - sample_ready = ~pend_full.
//   - On valid && ready, the converted sample goes into pending and pend_full is set.
// - Boundary edge, cnt == 2**WIDTH-1:
//   - If pend_full: pending -> active, pend_full cleared.
//   - Otherwise active holds (last sample repeats) and underrun pulses during the cycle cnt == 0.
//   - Transfer uses pending contents from before this edge. A sample accepted on this
//     same edge (pend_full was 0) lands in pending and plays next frame. It still counts
//     as underrun for this frame.
//   - mode is sampled into mode_q on the same edge; mode changes never split a frame.
//   - On the mode_q change edge, sigma-delta accumulators clear to 0.
// - PWM (mode_q == 0): dac_out[c] <= (cnt < active[c]).
//   - duty 0: constant low.
//   - duty 2**WIDTH-1: high 2**WIDTH-1 of 2**WIDTH cycles.
// - Sigma-delta (mode_q == 1):
//   - {carry, acc[c]} = acc[c] + active[c]  (acc is WIDTH bits; WIDTH+1-bit sum).
//   - dac_out[c] <= carry; acc[c] <= sum[WIDTH-1:0].
//   - Ones density per frame = active[c] / 2**WIDTH.
// - Output latency: dac_out is registered, 1 clk after the cnt/acc state it reflects.
// - mute: dac_out <= 0 and acc <= 0 while high. Counter, handshake and buffers keep running.
// - Reset (rst high at posedge):
//   - cnt = 0, acc = 0, pend_full = 0.
//   - active = 2**(WIDTH-1) (silence), mode_q = 0.
//   - dac_out = 0. During reset: sample_ready = 0, underrun = 0, frame_start = 0.
//   - First frame after release plays silence; ready is high on the first cycle after release.
//   - Reset mid-frame discards pending and active.
// TESTING  (defaults CHANNELS=2, IN_WIDTH=16, WIDTH=9)
// 1. Load ch0 = 0x0000, ch1 = 0x7FFF, mode 0; observe the next full frame
//    -> ch0 high 256/512 cycles, ch1 high 511/512; frame_start every 512 clk.
// 2. ch0 = 0x8000, mode 1 -> ch0 never high.
//    ch0 = 0x4000 (duty 384) -> exactly 384 ones per 512 cycles, at most 2 consecutive zeros.
// 3. Present a sample each cycle with valid held high -> exactly one accept per frame;
//    ready low from accept until the boundary edge; second sample value plays one frame later.
// 4. No sample for 3 frames -> underrun pulses 3 times; output repeats the last duty unchanged.
// 5. Toggle mode at cnt = 100 -> output stays PWM until cnt wraps, then sigma-delta with acc = 0.
//    Assert mute -> dac_out low the next cycle.
// 6. Assert rst at cnt = 300 with pending full -> next cycle dac_out = 0, ready = 0.
//    After release, one frame of 256/512 duty; ready = 1.

Source files
------------

// File: rtl/audio_dac.sv
// Multi-channel 1-bit audio DAC: PWM or first-order sigma-delta per pin.
// Samples are double-buffered (pending -> active) and swapped only at frame boundaries.
module audio_dac #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned WIDTH    = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*IN_WIDTH-1:0] sample,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         mode,
    input  logic                         mute,
    output logic                         frame_start,
    output logic                         underrun,
    output logic [CHANNELS-1:0]          dac_out
);

    localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Silence = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] cnt_q;
    logic             pend_full_q;
    logic             underrun_q;
    logic             mode_q;
    logic [WIDTH-1:0] pend_q   [CHANNELS];
    logic [WIDTH-1:0] active_q [CHANNELS];
    logic [WIDTH-1:0] acc_q    [CHANNELS];

    logic [WIDTH-1:0] duty     [CHANNELS];
    logic [WIDTH:0]   sum      [CHANNELS];
    logic             boundary;
    logic             accept;
    logic             mode_change;

    // Only the top WIDTH bits of each sample are converted; the rest are dropped on purpose.
    logic unused_sample_bits;
    assign unused_sample_bits = ^sample;

    assign boundary     = (cnt_q == CntMax);
    assign sample_ready = ~pend_full_q & ~rst;
    assign accept       = sample_valid & sample_ready;
    assign mode_change  = boundary & (mode != mode_q);
    assign frame_start  = (cnt_q == '0) & ~rst;
    assign underrun     = underrun_q & ~rst;

    // Signed PCM to offset binary, truncated to WIDTH bits; sigma-delta adder per channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            duty[c] = {~sample[c*IN_WIDTH + IN_WIDTH - 1],
                       sample[c*IN_WIDTH + IN_WIDTH - 2 -: WIDTH - 1]};
            sum[c]  = {1'b0, acc_q[c]} + {1'b0, active_q[c]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + 1'b1;
            underrun_q <= boundary & ~pend_full_q;
            if (boundary) begin
                mode_q <= mode;
            end
            // accept implies pending was empty, so it never collides with a transfer
            if (accept) begin
                pend_full_q <= 1'b1;
            end else if (boundary) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_out <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pend_q[c]   <= '0;
                active_q[c] <= Silence;
                acc_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept) begin
                    pend_q[c] <= duty[c];
                end
                if (boundary && pend_full_q) begin
                    active_q[c] <= pend_q[c];
                end

                if (mute) begin
                    dac_out[c] <= 1'b0;
                end else if (mode_q) begin
                    dac_out[c] <= sum[c][WIDTH];
                end else begin
                    dac_out[c] <= (cnt_q < active_q[c]);
                end

                if (mute || mode_change) begin
                    acc_q[c] <= '0;
                end else if (mode_q) begin
                    acc_q[c] <= sum[c][WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac.sv
// Directed bench for audio_dac: PWM/sigma-delta duty counts, handshake, underrun,
// mode switching at frame boundaries, mute and mid-frame reset.
module tb_audio_dac;

    logic        clk;
    logic        rst;
    logic [31:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        mode;
    logic        mute;
    logic        frame_start;
    logic        underrun;
    logic [1:0]  dac_out;

    audio_dac #(
        .CHANNELS (2),
        .IN_WIDTH (16),
        .WIDTH    (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mode         (mode),
        .mute         (mute),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .dac_out      (dac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side model of the frame counter.
    logic [8:0] exp_cnt;
    always @(posedge clk) begin
        if (rst) exp_cnt <= '0;
        else     exp_cnt <= exp_cnt + 9'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int         h0, h1, ur, fs_bad, run0, accepts;
    logic [7:0] pat0, pat1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cnt(input int c);
        for (int k = 0; k < 1100; k++) begin
            if (int'(exp_cnt) == c) break;
            @(negedge clk);
        end
        if (int'(exp_cnt) != c) check_eq("wait_cnt", 32'(exp_cnt), 32'(c));
    endtask

    // Samples one frame of output: cycles cnt=1..511,0, i.e. the edges cnt=0..511.
    task automatic count_frame(input int mode_at, input logic mode_val);
        int run;
        h0 = 0; h1 = 0; ur = 0; fs_bad = 0; run0 = 0; run = 0;
        pat0 = '0; pat1 = '0;
        wait_cnt(1);
        for (int i = 0; i < 512; i++) begin
            if (i > 0) @(negedge clk);
            if (int'(exp_cnt) == mode_at) mode = mode_val;
            if (dac_out[0] === 1'b1) h0++;
            if (dac_out[1] === 1'b1) h1++;
            if (underrun === 1'b1) ur++;
            if (frame_start !== (exp_cnt == 9'd0)) fs_bad++;
            if (dac_out[0] === 1'b1) run = 0;
            else run++;
            if (run > run0) run0 = run;
            if (i < 8) begin
                pat0 = {pat0[6:0], dac_out[0]};
                pat1 = {pat1[6:0], dac_out[1]};
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sample = '0; sample_valid = 1'b0; mode = 1'b0; mute = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dac_out", 32'(dac_out), 0);
        check_eq("rst_ready", 32'(sample_ready), 0);
        check_eq("rst_frame_start", 32'(frame_start), 0);
        check_eq("rst_underrun", 32'(underrun), 0);

        // Release; load ch0=0x0000 (duty 256), ch1=0x7FFF (duty 511).
        rst = 1'b0;
        #1;
        check_eq("rel_ready", 32'(sample_ready), 1);
        check_eq("rel_frame_start", 32'(frame_start), 1);
        sample = {16'h7FFF, 16'h0000};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check_eq("ready_after_accept", 32'(sample_ready), 0);

        count_frame(-1, 1'b0);
        check_eq("f0_silence_ch0", 32'(h0), 256);
        check_eq("f0_silence_ch1", 32'(h1), 256);
        check_eq("f0_underrun", 32'(ur), 0);
        check_eq("f0_frame_start", 32'(fs_bad), 0);
        check_eq("ready_after_boundary", 32'(sample_ready), 1);

        // Frames 1..3: loaded sample then repeats with underrun each frame.
        for (int f = 1; f <= 3; f++) begin
            count_frame(-1, 1'b0);
            check_eq($sformatf("f%0d_pwm_ch0", f), 32'(h0), 256);
            check_eq($sformatf("f%0d_pwm_ch1", f), 32'(h1), 511);
            check_eq($sformatf("f%0d_underrun", f), 32'(ur), 1);
            check_eq($sformatf("f%0d_frame_start", f), 32'(fs_bad), 0);
        end

        // Frame 4: valid held high; A then B. A: ch0 0x8000 (0), ch1 0x4000 (384).
        sample = {16'h4000, 16'h8000};
        sample_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) @(negedge clk);
            if (sample_ready === 1'b1) accepts++;
            if (i == 1) sample = {16'h0000, 16'h4000};
        end
        check_eq("one_accept_per_frame", 32'(accepts), 1);

        count_frame(-1, 1'b0);
        check_eq("f5_a_ch0", 32'(h0), 0);
        check_eq("f5_a_ch1", 32'(h1), 384);
        check_eq("f5_underrun", 32'(ur), 0);
        sample_valid = 1'b0;

        count_frame(-1, 1'b0);
        check_eq("f6_b_ch0", 32'(h0), 384);
        check_eq("f6_b_ch1", 32'(h1), 256);
        check_eq("f6_underrun", 32'(ur), 1);

        // Frame 7: mode raised at cnt 100 must not split the frame.
        count_frame(100, 1'b1);
        check_eq("f7_pwm_ch0", 32'(h0), 384);
        check_eq("f7_pwm_ch1", 32'(h1), 256);
        check_eq("f7_pwm_pat0", 32'(pat0), 32'h00FF);
        check_eq("f7_pwm_zero_run", 32'(run0), 128);

        // Frame 8: sigma-delta from acc=0; queue ch0=0x8000, ch1=0x7FFF for frame 9.
        sample = {16'h7FFF, 16'h8000};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        count_frame(-1, 1'b1);
        check_eq("f8_sd_ch0", 32'(h0), 384);
        check_eq("f8_sd_ch1", 32'(h1), 256);
        check_eq("f8_sd_pat0", 32'(pat0), 32'h0077);
        check_eq("f8_sd_pat1", 32'(pat1), 32'h0055);
        check_eq("f8_sd_zero_run", 32'(run0), 1);
        check_eq("f8_underrun", 32'(ur), 0);

        count_frame(-1, 1'b1);
        check_eq("f9_sd_ch0_never", 32'(h0), 0);
        check_eq("f9_sd_ch1", 32'(h1), 511);
        check_eq("f9_underrun", 32'(ur), 1);

        // Mute: outputs low next cycle, accumulators restart from 0 afterwards.
        wait_cnt(50);
        mute = 1'b1;
        @(negedge clk);
        check_eq("mute_low", 32'(dac_out), 0);
        mute = 1'b0;
        @(negedge clk);
        check_eq("unmute_first", 32'(dac_out), 0);
        @(negedge clk);
        check_eq("unmute_second", 32'(dac_out), 2);

        // Reset at cnt 300 with pending full.
        wait_cnt(100);
        sample = {16'h4000, 16'h4000};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check_eq("pend_full_ready", 32'(sample_ready), 0);
        wait_cnt(300);
        rst = 1'b1;
        mode = 1'b0;
        @(negedge clk);
        check_eq("midrst_dac_out", 32'(dac_out), 0);
        check_eq("midrst_ready", 32'(sample_ready), 0);
        check_eq("midrst_frame_start", 32'(frame_start), 0);
        check_eq("midrst_underrun", 32'(underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_rel_ready", 32'(sample_ready), 1);

        count_frame(-1, 1'b0);
        check_eq("r0_silence_ch0", 32'(h0), 256);
        check_eq("r0_silence_ch1", 32'(h1), 256);
        check_eq("r0_underrun", 32'(ur), 1);
        check_eq("r0_frame_start", 32'(fs_bad), 0);
        count_frame(-1, 1'b0);
        check_eq("r1_discarded_ch0", 32'(h0), 256);
        check_eq("r1_discarded_ch1", 32'(h1), 256);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
